stream_border_detect: RTL

- Streaming successor of the full-frame border detector. Accepts a raster-order pixel stream with valid/ready handshakes.
- Buffers two lines plus a 3x3 window and emits one border-classified pixel per accepted input.
- Width, height, pixel depth, threshold and output mode are configurable. Sits between the camera/frame source and the frame writer.

---
 rtl/stream_border_detect.sv | 132 +++++++++++++
 1 files changed

// File: rtl/stream_border_detect.sv
// stream_border_detect: streaming 3x3 border classifier over a raster-order valid/ready pixel stream
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cfg_thresh/cfg_mode threshold and mode (0 grey, 1 binary, 2 passthrough, 3 as 0), latched on accepted SOF
//   s_valid/s_ready/s_data/s_sof          input pixel stream, s_sof marks pixel (0,0)
//   m_valid/m_ready/m_data/m_sof/m_eof    classified output stream
//   busy                frame in flight (RUN or FLUSH)
//   sof_err             one-cycle pulse on an SOF accepted mid-frame
module stream_border_detect #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] cfg_thresh,
    input  logic [1:0]        cfg_mode,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sof,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sof,
    output logic              m_eof,
    output logic              busy,
    output logic              sof_err
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H + 2);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t state, state_nx;
    logic [XW-1:0] x, ax;
    logic [YW-1:0] y, ay;
    logic [DATA_W-1:0] thresh;
    logic [1:0] mode;
    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] w0 [3];
    logic [DATA_W-1:0] w1 [3];
    logic [DATA_W-1:0] col [3];
    logic [DATA_W-1:0] din, c, res;
    logic out_free, acc, sof_acc, adv, produce, border, lo, edge_hit, last_in;

    assign busy     = state != IDLE;
    assign out_free = !m_valid || m_ready;
    assign s_ready  = state == IDLE || (state == RUN && out_free);
    assign acc      = s_valid && s_ready;
    assign sof_acc  = acc && s_sof;
    // FLUSH feeds dummy pixels to push the last line and a pixel out; it stops once eof sits in the register
    assign adv      = sof_acc || (state == RUN && acc) || (state == FLUSH && out_free && !(m_valid && m_eof));
    // An SOF always restarts the frame at input index 0
    assign ax       = sof_acc ? '0 : x;
    assign ay       = sof_acc ? '0 : y;
    assign din      = state == FLUSH ? '0 : s_data;
    assign last_in  = ax == XW'(IMG_W - 1) && ay == YW'(IMG_H - 1);
    // Input (ax,ay) completes the window centred one line up and one pixel left
    assign produce  = !sof_acc && (ay >= YW'(2) || (ay == YW'(1) && ax != '0));
    // Centre column is ax-1; ax==0 wraps to the right edge of the line above, itself a border pixel
    assign border   = ax == '0 || ax == XW'(1) || ay == YW'(1) || ay == YW'(IMG_H);
    assign col[0]   = lb1[ax];
    assign col[1]   = lb0[ax];
    assign col[2]   = din;
    assign c        = w1[1];

    always_comb begin
        lo = (w1[0] < thresh) || (w1[2] < thresh);
        for (int k = 0; k < 3; k++) lo = lo || (w0[k] < thresh) || (col[k] < thresh);
    end

    assign edge_hit = c > thresh && lo;
    assign res      = mode == 2'd2 ? c : border ? '0 : edge_hit ? (mode == 2'd1 ? '1 : c) : '0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = sof_acc ? RUN : IDLE;
            RUN:     state_nx = acc && !sof_acc && last_in ? FLUSH : RUN;
            FLUSH:   state_nx = m_valid && m_eof && m_ready ? IDLE : FLUSH;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            x       <= '0;
            y       <= '0;
            thresh  <= '0;
            mode    <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sof   <= 1'b0;
            m_eof   <= 1'b0;
            sof_err <= 1'b0;
        end else begin
            state   <= state_nx;
            sof_err <= sof_acc && state == RUN;
            if (sof_acc) begin
                thresh <= cfg_thresh;
                mode   <= cfg_mode == 2'd3 ? 2'd0 : cfg_mode;
            end
            if (adv) begin
                x <= ax == XW'(IMG_W - 1) ? '0 : ax + 1'b1;
                y <= ax == XW'(IMG_W - 1) ? ay + 1'b1 : ay;
            end
            if (adv && produce) begin
                m_valid <= 1'b1;
                m_data  <= res;
                m_sof   <= ax == XW'(1) && ay == YW'(1);
                m_eof   <= ax == '0 && ay == YW'(IMG_H + 1);
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            lb1[ax] <= lb0[ax];
            lb0[ax] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            w0 <= w1;
            w1 <= col;
        end
    end
endmodule
